// File: rtl/handshake_pkg.sv
// Shared types and helpers for the handshake datapath elastic buffer.
package handshake_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef logic [DATA_W-1:0] data_t;

  // Pointer width for a given storage depth; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    if (depth < 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(depth);
    end
  endfunction

  // Occupancy type for the default depth: one extra bit so "full" is representable.
  typedef logic [ptr_width(FIFO_DEPTH):0] level_t;

endpackage

// File: rtl/handshake_fifo_checker.sv
// Simulation sanity checks on the buffer's occupancy bookkeeping.
module handshake_fifo_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             pop,
  input logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (level == FULL_LVL)));

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst)
    !(pop && (level == {LVL_W{1'b0}})));

  a_level_in_range: assert property (@(posedge clk) disable iff (!rst)
    (level <= FULL_LVL));

endmodule

// File: rtl/handshake_fifo_mem.sv
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous read port.
// The data array carries no reset; validity is tracked by the occupancy logic in the top.
module handshake_fifo_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the incoming word at the write address on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic buffer between producer and consumer stages with valid/ready on both sides.
// Ready and valid are registered, so there is no combinational path between the channels.
module handshake_fifo
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned STALL_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [STALL_W-1:0]     stall_cnt
);

  localparam int unsigned      PTR_W    = ptr_width(DEPTH);
  localparam int unsigned      LVL_W    = PTR_W + 32'd1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic               push_s;
  logic               pop_s;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   rdata_s;

  // Handshake decode plus next-state for pointers, occupancy and stall counter.
  always_comb begin
    push_s = in_valid & in_ready_q;
    pop_s  = out_valid_q & out_ready;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    level_d = level_q + LVL_W'(push_s) - LVL_W'(pop_s);

    if (out_valid_q && !out_ready && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers; reset discards contents immediately and holds in_ready low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      level_q     <= {LVL_W{1'b0}};
      stall_q     <= {STALL_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      stall_q     <= stall_d;
      in_ready_q  <= (level_d != FULL_LVL);
      out_valid_q <= (level_d != {LVL_W{1'b0}});
    end
  end

  handshake_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rdata_s)
  );

  handshake_fifo_checker #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_checker (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .level (level_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  // Stale array contents are hidden while empty so reset presents zero.
  assign out_data  = out_valid_q ? rdata_s : {WIDTH{1'b0}};
  assign level     = level_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_handshake_fifo.sv
// Self-checking bench for handshake_fifo: table vectors, directed corner sequences
// and random traffic compared against a queue-based reference model.
module tb_handshake_fifo;

  localparam int DEPTH   = 4;
  localparam int STALL_W = 4;
  localparam int SAT     = (1 << STALL_W) - 1;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic [2:0]         level;
  logic [STALL_W-1:0] stall_cnt;

  handshake_fifo #(
    .WIDTH   (32),
    .DEPTH   (DEPTH),
    .STALL_W (STALL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] q[$];
  bit          ready_m;
  int          stall_ref;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    int          e_lvl;
    logic [31:0] e_od;
    int          e_stall;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, sample 1ns later.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy);
    bit push_m, pop_m, stall_m;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    push_m  = iv && ready_m;
    pop_m   = (q.size() != 0) && ordy;
    stall_m = (q.size() != 0) && !ordy;
    @(posedge clk);
    if (pop_m) void'(q.pop_front());
    if (push_m) q.push_back(d);
    ready_m = (q.size() != DEPTH);
    if (stall_m && stall_ref != SAT) stall_ref++;
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_level"}, 64'(level), 64'(q.size()));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(ready_m));
    chk({tag, "_stall"}, 64'(stall_cnt), 64'(stall_ref));
    if (q.size() != 0) chk({tag, "_out_data"}, 64'(out_data), 64'(q[0]));
  endtask

  // Assert reset (asynchronously), check outputs, hold 3 edges, release at negedge.
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    q.delete();
    ready_m   = 1'b0;
    stall_ref = 0;
    #1;
    chk("rst_async_in_ready", 64'(in_ready), 64'd0);
    chk("rst_async_out_valid", 64'(out_valid), 64'd0);
    chk("rst_async_level", 64'(level), 64'd0);
    chk("rst_async_stall", 64'(stall_cnt), 64'd0);
    chk("rst_async_out_data", 64'(out_data), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_in_ready_low", 64'(in_ready), 64'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;

    //              iv    data    ordy  ir    ov    lvl od      stall
    tbl[0] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b1, 1, 32'hA0, 0};
    tbl[1] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 2, 32'hA0, 1};
    tbl[2] = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 3, 32'hA0, 2};
    tbl[3] = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 4, 32'hA0, 3};
    tbl[4] = '{1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 4, 32'hA0, 4};
    tbl[5] = '{1'b1, 32'hA5, 1'b0, 1'b0, 1'b1, 4, 32'hA0, 5};
    tbl[6] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3, 32'hA1, 5};
    tbl[7] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 2, 32'hA2, 5};
    tbl[8] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1, 32'hA3, 5};
    tbl[9] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 0, 32'h00, 5};

    // Reset release: in_ready rises one edge after release
    do_reset();
    step(1'b0, 32'd0, 1'b0);
    chk("ready_after_release", 64'(in_ready), 64'd1);
    check_model("release");

    // Streaming with consumer always ready
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 32'(i), 1'b1);
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_level_max", 64'(level <= 3'd1), 64'd1);
      check_model("stream");
    end
    step(1'b0, 32'd0, 1'b1);
    check_model("stream_drain");

    // Fill and back-pressure, table driven
    do_reset();
    step(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].e_ir));
      chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].e_ov));
      chk("tbl_level", 64'(level), 64'(tbl[i].e_lvl));
      chk("tbl_stall", 64'(stall_cnt), 64'(tbl[i].e_stall));
      if (tbl[i].e_ov) chk("tbl_out_data", 64'(out_data), 64'(tbl[i].e_od));
    end

    // Simultaneous push/pop at level 2 across pointer wrap
    do_reset();
    step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'hB0, 1'b0);
    step(1'b1, 32'hB1, 1'b0);
    check_model("pp_prefill");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom, 1'b1);
      chk("pp_level_const", 64'(level), 64'd2);
      check_model("pp");
    end

    // Mid-operation reset between clock edges
    do_reset();
    step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'hC0, 1'b0);
    step(1'b1, 32'hC1, 1'b0);
    step(1'b1, 32'hC2, 1'b0);
    chk("midrst_level3", 64'(level), 64'd3);
    #2;
    do_reset();
    step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h5A, 1'b0);
    chk("midrst_first_out", 64'(out_data), 64'h5A);
    check_model("midrst");
    step(1'b0, 32'd0, 1'b1);
    chk("midrst_empty_after", 64'(out_valid), 64'd0);
    check_model("midrst_end");

    // Stall counter saturation
    do_reset();
    step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'hD0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'd0, 1'b0);
      check_model("sat");
    end
    chk("sat_value", 64'(stall_cnt), 64'(SAT));
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("sat_hold", 64'(stall_cnt), 64'(SAT));
    do_reset();

    // Random traffic against the reference model
    step(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic iv, ordy;
      int   bias;
      bias = (i < 200) ? 70 : 30;
      iv   = ($urandom_range(0, 99) < bias);
      ordy = ($urandom_range(0, 99) < (100 - bias));
      step(iv, $urandom, ordy);
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_fifo.md
Name: handshake_fifo

Overview:
- Elastic buffer stage between a producer stage (source side) and a consumer stage (drain side) of the handshake datapath.
- Accepts words on a valid/ready input channel, stores up to DEPTH words, and presents them in order on a valid/ready output channel.
- Decouples producer stalls from consumer back-pressure and counts consumer stall cycles for bring-up.

Parameters:
- WIDTH, 32, data word width in bits; matches the handshake interface WIDTH.
- DEPTH, 4, storage entries; power of two, >= 2.
- STALL_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  buffer can accept a word this cycle.
- in_data  input  WIDTH  producer word.
- out_valid  output  1  out_data holds the oldest stored word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  oldest stored word.
- level  output  $clog2(DEPTH)+1  number of words currently stored.
- stall_cnt  output  STALL_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst=0, asynchronous): level=0, read/write pointers=0, out_valid=0, in_ready=0, stall_cnt=0. out_data is don't-care; the implementation drives 0.
- in_ready is a registered signal. It rises on the first rising edge after rst deasserts. Thereafter in_ready(t+1) = (level_next != DEPTH).
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Push writes in_data at wr_ptr, then wr_ptr increments modulo DEPTH (natural wrap, pointers are $clog2(DEPTH) bits).
- Pop advances rd_ptr modulo DEPTH.
- level_next = level + push - pop. Push and pop in the same cycle leave level unchanged.
- out_valid = (level != 0). out_data = mem[rd_ptr].
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N. There is no combinational bypass from in_data to out_data.
- Throughput: one word per cycle sustained when the consumer holds out_ready=1, for any DEPTH >= 2.
- Full (level=DEPTH): in_ready=0 and in_valid is ignored. A pop in the full cycle raises in_ready in the next cycle. There is no same-cycle full-pop-push pass-through, so no combinational ready path exists.
- Empty (level=0): out_valid=0 and out_ready is ignored. A push while empty produces out_valid=1 in the next cycle.
- Ordering: strict FIFO, no reordering, no drop.
- stall_cnt increments each cycle with out_valid & !out_ready, saturates at all-ones, and clears only on reset.
- Reset mid-operation: stored contents are discarded immediately. Outputs return to their reset values asynchronously. The first push after release lands at entry 0.
- Sanity checks (simulation only):
  - assert no push when level=DEPTH;
  - assert no pop when level=0;
  - assert level <= DEPTH at all times.

Decomposition:
- Package handshake_pkg:
  - localparam DATA_W=32;
  - typedef logic [DATA_W-1:0] data_t;
  - function clog2-based PTR_W helper;
  - typedef for the level type.
- Sub-module handshake_fifo_mem: DEPTH x WIDTH register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). It has no reset on the data array.
- Pointer, level, ready and stall logic stay in handshake_fifo.

Test Plan:
- Reset release: hold rst=0 for 3 cycles, then release → in_ready=0 during reset and 1 one edge after release; out_valid=0, level=0, stall_cnt=0.
- Streaming: out_ready=1, push 0x00000001..0x00000010 on consecutive cycles → the same 16 values appear in order, one per cycle, first value one cycle after the first push; level never exceeds 1.
- Fill and back-pressure (DEPTH=4): out_ready=0, push 0xA0..0xA5 → only 0xA0..0xA3 accepted; in_ready=0 after the 4th push; level=4; stall_cnt increments every cycle with out_valid=1. Then raise out_ready → 0xA0..0xA3 drain in order, and in_ready returns one cycle after the first pop.
- Simultaneous push/pop at level=2 for 20 cycles → level stays at 2; pointers wrap past DEPTH with no data corruption (scoreboard matches).
- Mid-operation reset: with level=3, pulse rst=0 between clock edges → out_valid and level drop to 0 without a clock edge. After release, push 0x5A → it emerges first and nothing from before the reset is seen.
- Stall saturation (STALL_W=4): hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt stops at 15 and holds until reset.
